rom_ctrl_exp_digest_loader: RTL and testbench
=============================================

// Module: rom_ctrl_exp_digest_loader
// PURPOSE
//  Fetches the expected-digest words from the top NumWords locations of ROM and writes them into a
//  flat EXP_DIGEST register in word order. When all words are loaded it pulses cmp_start_o to
//  launch the digest comparator, which consumes exp_digest_o.
//  Sits between the ROM read port and the comparator inside the ROM checker.
// PARAMETERS
//  NumWords  8     number of 32-bit expected-digest words (>=1)
//  RomDepth  8192  ROM depth in 32-bit words (> NumWords)
//  AW        vbits(RomDepth)  localparam: ROM address width
//  CW        vbits(NumWords)  localparam: word-index counter width
// PORTS
//  clk_i         in   1              clock
//  rst_i         in   1              synchronous reset, active-high
//  start_i       in   1              begin load; honoured only in Idle
//  rom_req_o     out  1              ROM read request, held until granted
//  rom_addr_o    out  AW             ROM word address, stable while rom_req_o is high
//  rom_gnt_i     in   1              request accepted this cycle
//  rom_rvalid_i  in   1              read data valid
//  rom_rdata_i   in   32             read data
//  exp_digest_o  out  NumWords*32    loaded digest; word i at [32*i +: 32]
//  busy_o        out  1              high in Req or Wait
//  done_o        out  1              high while in Done
//  cmp_start_o   out  1              one-cycle pulse on entry to Done
//  alert_o       out  1              sticky fatal alert
// BEHAVIOUR
//  - Reset (rst_i high at a clock edge): state=Idle, idx=0, exp_digest_o=0, alert_o=0, all
//    request/status outputs 0. Reset applied mid-load aborts the load; no request stays pending.
//  - Sparse FSM, 5 bits, minimum Hamming distance 3: Idle=5'b00101 Req=5'b11000 Wait=5'b01110
//    Done=5'b10011.
//  - Idle: start_i -> Req (idx=0).
//  - Req: rom_req_o=1, rom_addr_o=RomDepth-NumWords+idx. rom_gnt_i -> Wait. Only one request
//    is outstanding at a time.
//  - Wait: rom_req_o=0. On rom_rvalid_i, write rom_rdata_i to word idx in the same edge.
//    If idx==NumWords-1 -> Done, else idx++ -> Req.
//    Minimum request-to-request spacing is 2 cycles (gnt, rvalid then re-request).
//  - Done: terminal. Only reset leaves it. exp_digest_o holds its value.
//    cmp_start_o is asserted in the first Done cycle only.
//  - Latency: with gnt in the request cycle and rvalid one cycle later, Done is entered
//    2*NumWords+1 cycles after start_i is sampled.
//  - Address arithmetic is at AW bits. idx never wraps.
//  - alert_o is set (sticky until reset) on any of the following:
//    - undefined state encoding;
//    - start_i while not in Idle;
//    - rom_rvalid_i outside Wait;
//    - idx != 0 in Idle;
//    - idx != NumWords-1 in Done.
//    On alert the FSM is forced to Done without pulsing cmp_start_o.
//    exp_digest_o freezes.
//  - Simultaneous start_i with rst_i: reset wins.
//  - rom_gnt_i outside Req is ignored.
// CONFIGURATION
//  ROM_CTRL_LOADER_DUP_CNT_EN
//   defined: idx is duplicated as a down-counter idx_n = NumWords-1-idx.
//            Any cycle where idx+idx_n != NumWords-1 sets alert_o.
//   undefined: single counter only, no counter-consistency alert; all other behaviour identical.
// TESTING
//  1. NumWords=8, RomDepth=8192, gnt same cycle, rvalid +1.
//     ROM returns 0xA0000000+addr -> reads addresses 8184..8191 in order.
//     exp_digest_o word i = 0xA0001FF8+i. cmp_start_o pulses once, 17 cycles after start.
//  2. gnt delayed 3 cycles per request -> rom_req_o and rom_addr_o stay stable across the stall.
//     Final data is identical to scenario 1. No alert.
//  3. start_i pulsed during Wait -> alert_o=1 next cycle, state Done, cmp_start_o never pulses.
//  4. rom_rvalid_i asserted in Idle -> alert_o=1. A following rst_i clears alert_o and
//     exp_digest_o to 0.
//  5. rst_i asserted after word 3 is loaded -> Idle, outputs 0. A new start_i completes a full
//     clean load.
//  6. ROM_CTRL_LOADER_DUP_CNT_EN defined: force idx_n bit flip mid-load -> alert_o=1 next cycle.

Source files
------------

// File: rtl/rom_ctrl_exp_digest_loader.sv
// Loads the expected-digest words from the top NumWords ROM locations, then kicks the comparator.
// Build option: ROM_CTRL_LOADER_DUP_CNT_EN adds a redundant down-counter cross-check on idx.
module rom_ctrl_exp_digest_loader #(
  parameter int NumWords = 8,
  parameter int RomDepth = 8192,
  localparam int AW = (RomDepth > 1) ? $clog2(RomDepth) : 1,
  localparam int CW = (NumWords > 1) ? $clog2(NumWords) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  output logic                     rom_req_o,
  output logic [AW-1:0]            rom_addr_o,
  input  logic                     rom_gnt_i,
  input  logic                     rom_rvalid_i,
  input  logic [31:0]              rom_rdata_i,
  output logic [NumWords*32-1:0]   exp_digest_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     cmp_start_o,
  output logic                     alert_o
);

  // Sparse encodings, pairwise Hamming distance >= 3.
  typedef enum logic [4:0] {
    StIdle = 5'b00101,
    StReq  = 5'b11000,
    StWait = 5'b01110,
    StDone = 5'b10011
  } state_e;

  localparam logic [AW-1:0] BaseAddr = AW'(RomDepth - NumWords);
  localparam logic [CW-1:0] LastIdx  = CW'(NumWords - 1);

  state_e        state_reg, state_next;
  logic [CW-1:0] idx_reg, idx_next;
  logic          alert_reg, alert_next;
  logic          cmp_reg, cmp_next;
  logic          wr_en;
  logic          bad_state;
  logic          fault;
  logic          cnt_fault;

`ifdef ROM_CTRL_LOADER_DUP_CNT_EN
  logic [CW-1:0] idx_n_reg, idx_n_next;
  assign cnt_fault = (({1'b0, idx_reg} + {1'b0, idx_n_reg}) != {1'b0, LastIdx});
`else
  assign cnt_fault = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    alert_next = alert_reg;
    cmp_next   = 1'b0;
    wr_en      = 1'b0;
    bad_state  = 1'b0;
    rom_req_o  = 1'b0;
    rom_addr_o = '0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
`ifdef ROM_CTRL_LOADER_DUP_CNT_EN
    idx_n_next = idx_n_reg;
`endif
    case (state_reg)
      StIdle: begin
        if (start_i) begin
          state_next = StReq;
          idx_next   = '0;
`ifdef ROM_CTRL_LOADER_DUP_CNT_EN
          idx_n_next = LastIdx;
`endif
        end
      end
      StReq: begin
        rom_req_o  = 1'b1;
        rom_addr_o = BaseAddr + AW'(idx_reg);
        busy_o     = 1'b1;
        if (rom_gnt_i) state_next = StWait;
      end
      StWait: begin
        busy_o = 1'b1;
        if (rom_rvalid_i) begin
          wr_en = 1'b1;
          if (idx_reg == LastIdx) begin
            state_next = StDone;
            cmp_next   = 1'b1;
          end else begin
            state_next = StReq;
            idx_next   = idx_reg + 1'b1;
`ifdef ROM_CTRL_LOADER_DUP_CNT_EN
            idx_n_next = idx_n_reg - 1'b1;
`endif
          end
        end
      end
      StDone: done_o = 1'b1;
      default: bad_state = 1'b1;
    endcase

    fault = bad_state
          || (start_i && state_reg != StIdle)
          || (rom_rvalid_i && state_reg != StWait)
          || (state_reg == StIdle && idx_reg != '0)
          || (state_reg == StDone && idx_reg != LastIdx)
          || cnt_fault;

    // Any fault parks the FSM in Done with the digest frozen and no comparator kick.
    if (fault || alert_reg) begin
      state_next = StDone;
      idx_next   = idx_reg;
      wr_en      = 1'b0;
      cmp_next   = 1'b0;
      alert_next = 1'b1;
`ifdef ROM_CTRL_LOADER_DUP_CNT_EN
      idx_n_next = idx_n_reg;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= StIdle;
      idx_reg   <= '0;
      alert_reg <= 1'b0;
      cmp_reg   <= 1'b0;
`ifdef ROM_CTRL_LOADER_DUP_CNT_EN
      idx_n_reg <= LastIdx;
`endif
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      alert_reg <= alert_next;
      cmp_reg   <= cmp_next;
`ifdef ROM_CTRL_LOADER_DUP_CNT_EN
      idx_n_reg <= idx_n_next;
`endif
    end
  end

  for (genvar gi = 0; gi < NumWords; gi++) begin : g_word
    logic [31:0] word_reg;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        word_reg <= '0;
      end else if (wr_en && idx_reg == CW'(gi)) begin
        word_reg <= rom_rdata_i;
      end
    end
    assign exp_digest_o[32*gi +: 32] = word_reg;
  end

  assign cmp_start_o = cmp_reg;
  assign alert_o     = alert_reg;

endmodule

// File: tb/tb_rom_ctrl_exp_digest_loader.sv
// Directed bench for the expected-digest loader with a small ROM responder model.
module tb_rom_ctrl_exp_digest_loader;
  localparam int NW = 8;
  localparam int AW = 13;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            start_i = 1'b0;
  logic            rom_req_o;
  logic [AW-1:0]   rom_addr_o;
  logic            rom_gnt_i;
  logic            rom_rvalid_i;
  logic [31:0]     rom_rdata_i;
  logic [NW*32-1:0] exp_digest_o;
  logic            busy_o, done_o, cmp_start_o, alert_o;

  logic            resp_gnt = 1'b0, resp_rvalid = 1'b0, inj_rvalid = 1'b0;
  logic [31:0]     resp_rdata = '0;

  assign rom_gnt_i    = resp_gnt;
  assign rom_rvalid_i = resp_rvalid | inj_rvalid;
  assign rom_rdata_i  = resp_rdata;

  rom_ctrl_exp_digest_loader #(.NumWords(NW), .RomDepth(8192)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_gnt_i(rom_gnt_i),
    .rom_rvalid_i(rom_rvalid_i), .rom_rdata_i(rom_rdata_i),
    .exp_digest_o(exp_digest_o), .busy_o(busy_o), .done_o(done_o),
    .cmp_start_o(cmp_start_o), .alert_o(alert_o)
  );

  always #5 clk_i = ~clk_i;

  int pass_cnt = 0, chk_cnt = 0;

  // ROM responder: grants after gnt_delay stalled cycles, returns data one cycle after grant.
  int          gnt_delay = 0, wait_cnt = 0;
  logic        pend = 1'b0, req_seen = 1'b0;
  logic [AW-1:0] paddr = '0, req_addr = '0;
  int          rv_count = 0, stall_cnt = 0, stall_err = 0, cmp_cnt = 0;
  logic [AW-1:0] addr_log [NW];

  always @(negedge clk_i) begin
    resp_gnt = 1'b0;
    resp_rvalid = 1'b0;
    cmp_cnt += int'(cmp_start_o);
    if (rst_i) begin
      pend = 1'b0; req_seen = 1'b0; wait_cnt = 0;
    end else if (pend) begin
      resp_rvalid = 1'b1;
      resp_rdata  = 32'hA000_0000 + 32'(paddr);
      pend = 1'b0;
      rv_count++;
    end else if (rom_req_o) begin
      if (!req_seen) begin
        req_seen = 1'b1; req_addr = rom_addr_o;
      end else if (rom_addr_o != req_addr) begin
        stall_err++;
      end
      if (wait_cnt >= gnt_delay) begin
        resp_gnt = 1'b1; paddr = rom_addr_o; pend = 1'b1; wait_cnt = 0; req_seen = 1'b0;
        if (rv_count < NW) addr_log[rv_count] = rom_addr_o;
      end else begin
        wait_cnt++; stall_cnt++;
      end
    end else if (req_seen) begin
      stall_err++;
    end
  end

  task automatic do_reset;
    rst_i = 1'b1; start_i = 1'b0; inj_rvalid = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    rv_count = 0; stall_cnt = 0; stall_err = 0; cmp_cnt = 0;
  endtask

  task automatic run_load(input int delay, output int lat);
    gnt_delay = delay;
    start_i = 1'b1;
    lat = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
      lat++;
      if (cmp_start_o) break;
    end
    $display("load delay=%0d latency=%0d digest=%h", delay, lat, exp_digest_o);
  endtask

  task automatic check_load(input string tag);
    logic [31:0] w;
    for (int i = 0; i < NW; i++) begin
      w = exp_digest_o[32*i +: 32];
      chk_cnt++;
      if (w !== 32'hA000_1FF8 + 32'(i))
        $display("FAIL %s word%0d got=%h exp=%h", tag, i, w, 32'hA000_1FF8 + 32'(i));
      else pass_cnt++;
      chk_cnt++;
      if (addr_log[i] !== AW'(8184 + i))
        $display("FAIL %s addr%0d got=%0d exp=%0d", tag, i, addr_log[i], 8184 + i);
      else pass_cnt++;
    end
    chk_cnt++;
    if (alert_o !== 1'b0) $display("FAIL %s alert got=%b exp=0", tag, alert_o); else pass_cnt++;
    chk_cnt++;
    if ({done_o, busy_o} !== 2'b10) $display("FAIL %s done/busy got=%b exp=10", tag, {done_o, busy_o}); else pass_cnt++;
    repeat (3) @(posedge clk_i);
    #1;
    chk_cnt++;
    if (cmp_cnt !== 1) $display("FAIL %s cmp_pulses got=%0d exp=1", tag, cmp_cnt); else pass_cnt++;
    chk_cnt++;
    if ({cmp_start_o, done_o} !== 2'b01) $display("FAIL %s hold cmp/done got=%b exp=01", tag, {cmp_start_o, done_o}); else pass_cnt++;
    chk_cnt++;
    if (exp_digest_o[32*(NW-1) +: 32] !== 32'hA000_1FFF)
      $display("FAIL %s held_last got=%h exp=a0001fff", tag, exp_digest_o[32*(NW-1) +: 32]);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    do_reset();
    $display("reset: req=%b busy=%b done=%b alert=%b", rom_req_o, busy_o, done_o, alert_o);
    chk_cnt++;
    if ({rom_req_o, busy_o, done_o, cmp_start_o, alert_o} !== 5'b0)
      $display("FAIL reset_status got=%b exp=00000", {rom_req_o, busy_o, done_o, cmp_start_o, alert_o});
    else pass_cnt++;
    chk_cnt++;
    if (exp_digest_o !== '0) $display("FAIL reset_digest got=%h exp=0", exp_digest_o); else pass_cnt++;
    chk_cnt++;
    if (rom_addr_o !== '0) $display("FAIL reset_addr got=%0d exp=0", rom_addr_o); else pass_cnt++;
  endtask

  task automatic test_basic_load;
    int lat;
    do_reset();
    run_load(0, lat);
    chk_cnt++;
    if (lat !== 17) $display("FAIL basic_latency got=%0d exp=17", lat); else pass_cnt++;
    check_load("basic");
  endtask

  task automatic test_gnt_stall;
    int lat;
    do_reset();
    run_load(3, lat);
    chk_cnt++;
    if (lat !== 41) $display("FAIL stall_latency got=%0d exp=41", lat); else pass_cnt++;
    chk_cnt++;
    if (stall_cnt !== 24) $display("FAIL stall_cycles got=%0d exp=24", stall_cnt); else pass_cnt++;
    chk_cnt++;
    if (stall_err !== 0) $display("FAIL stall_req_stable got=%0d exp=0", stall_err); else pass_cnt++;
    check_load("stall");
  endtask

  task automatic test_start_in_wait;
    bit found = 1'b0;
    do_reset();
    gnt_delay = 0;
    start_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
      if (busy_o && !rom_req_o) begin found = 1'b1; break; end
    end
    chk_cnt++;
    if (!found) $display("FAIL start_wait reach_wait got=0 exp=1"); else pass_cnt++;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    $display("start in wait: alert=%b done=%b", alert_o, done_o);
    chk_cnt++;
    if ({alert_o, done_o, busy_o, cmp_start_o} !== 4'b1100)
      $display("FAIL start_wait alert/done/busy/cmp got=%b exp=1100", {alert_o, done_o, busy_o, cmp_start_o});
    else pass_cnt++;
    repeat (5) @(posedge clk_i);
    #1;
    chk_cnt++;
    if (cmp_cnt !== 0) $display("FAIL start_wait cmp_pulses got=%0d exp=0", cmp_cnt); else pass_cnt++;
    chk_cnt++;
    if (exp_digest_o !== '0) $display("FAIL start_wait frozen got=%h exp=0", exp_digest_o); else pass_cnt++;
    chk_cnt++;
    if (alert_o !== 1'b1) $display("FAIL start_wait sticky got=%b exp=1", alert_o); else pass_cnt++;
  endtask

  task automatic test_rvalid_idle;
    do_reset();
    inj_rvalid = 1'b1;
    @(posedge clk_i); #1;
    inj_rvalid = 1'b0;
    $display("rvalid in idle: alert=%b done=%b", alert_o, done_o);
    chk_cnt++;
    if ({alert_o, done_o, cmp_start_o} !== 3'b110)
      $display("FAIL rvalid_idle alert/done/cmp got=%b exp=110", {alert_o, done_o, cmp_start_o});
    else pass_cnt++;
    do_reset();
    chk_cnt++;
    if ({alert_o, done_o} !== 2'b00) $display("FAIL rvalid_idle_clear got=%b exp=00", {alert_o, done_o}); else pass_cnt++;
    chk_cnt++;
    if (exp_digest_o !== '0) $display("FAIL rvalid_idle_digest got=%h exp=0", exp_digest_o); else pass_cnt++;
  endtask

  task automatic test_reset_midload;
    bit found = 1'b0;
    int lat;
    do_reset();
    gnt_delay = 0;
    start_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
      if (rv_count == 4) begin found = 1'b1; break; end
    end
    chk_cnt++;
    if (!found || exp_digest_o[32*3 +: 32] !== 32'hA000_1FFB)
      $display("FAIL midload word3 got=%h exp=a0001ffb", exp_digest_o[32*3 +: 32]);
    else pass_cnt++;
    do_reset();
    $display("reset mid-load: busy=%b req=%b digest=%h", busy_o, rom_req_o, exp_digest_o);
    chk_cnt++;
    if ({busy_o, rom_req_o, done_o, alert_o} !== 4'b0)
      $display("FAIL midload_status got=%b exp=0000", {busy_o, rom_req_o, done_o, alert_o});
    else pass_cnt++;
    chk_cnt++;
    if (exp_digest_o !== '0) $display("FAIL midload_digest got=%h exp=0", exp_digest_o); else pass_cnt++;
    run_load(0, lat);
    chk_cnt++;
    if (lat !== 17) $display("FAIL reload_latency got=%0d exp=17", lat); else pass_cnt++;
    check_load("reload");
  endtask

`ifdef ROM_CTRL_LOADER_DUP_CNT_EN
  task automatic test_dup_cnt;
    logic [2:0] flipped;
    do_reset();
    gnt_delay = 0;
    start_i = 1'b1;
    repeat (5) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
    end
    flipped = dut.idx_n_reg ^ 3'b001;
    force dut.idx_n_reg = flipped;
    @(posedge clk_i); #1;
    release dut.idx_n_reg;
    $display("dup counter flip: alert=%b done=%b", alert_o, done_o);
    chk_cnt++;
    if ({alert_o, done_o} !== 2'b11) $display("FAIL dup_cnt alert/done got=%b exp=11", {alert_o, done_o}); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_gnt_stall();
    test_start_in_wait();
    test_rvalid_idle();
    test_reset_midload();
`ifdef ROM_CTRL_LOADER_DUP_CNT_EN
    test_dup_cnt();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
